uart_value_reporter: RTL



---
 rtl/uart_value_reporter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/uart_value_reporter.sv
// uart_value_reporter: sends the 4-bit counter value as "<hex>\r\n" over 8N1 UART.
// Changes and resend requests coalesce so the host always sees the latest value.
module uart_value_reporter #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       FPGA_CLK,
  input  logic       rst_butt,
  input  logic [3:0] data,
  input  logic       force_send,
  output logic       UART_TXD,
  output logic       busy,
  output logic       msg_done
);

  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] v);
    if (v < 4'd10) return 8'h30 + {4'h0, v};
    else           return 8'h37 + {4'h0, v};
  endfunction

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [1:0]    r_idx;
  logic [7:0]    r_shift;
  logic [3:0]    r_data_q;
  logic          r_pending;
  logic          r_txd;
  logic          r_busy;
  logic          r_done;

  state_t        w_state_n;
  logic [CW-1:0] w_cnt_n;
  logic [2:0]    w_bit_n;
  logic [1:0]    w_idx_n;
  logic [7:0]    w_shift_n;
  logic          w_txd_n;
  logic          w_done_n;
  logic          w_take;
  logic          w_tick;
  logic          w_chg;

  assign w_tick = (r_cnt == CNT_LAST);
  assign w_chg  = (data != r_data_q) | force_send;

  // Next-state, bit timing and next line level; outputs are registered from these.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt + CW'(1);
    w_bit_n   = r_bit;
    w_idx_n   = r_idx;
    w_shift_n = r_shift;
    w_done_n  = 1'b0;
    w_take    = 1'b0;
    w_txd_n   = 1'b1;
    if (r_state == S_IDLE || w_tick) w_cnt_n = '0;
    unique case (r_state)
      S_IDLE: begin
        if (r_pending) begin
          w_state_n = S_START;
          w_shift_n = hex_ascii(data);
          w_idx_n   = 2'd0;
          w_take    = 1'b1;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_state_n = S_DATA;
          w_bit_n   = 3'd0;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_shift_n = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) w_state_n = S_STOP;
          else               w_bit_n   = r_bit + 3'd1;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (r_idx < 2'd2) begin
            w_idx_n   = r_idx + 2'd1;
            w_shift_n = (r_idx == 2'd0) ? 8'h0D : 8'h0A;
            w_state_n = S_START;
          end else begin
            w_state_n = S_IDLE;
            w_done_n  = 1'b1;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
    unique case (1'b1)
      (w_state_n == S_START): w_txd_n = 1'b0;
      (w_state_n == S_DATA):  w_txd_n = w_shift_n[0];
      default:                w_txd_n = 1'b1;
    endcase
  end

  // State, datapath and registered outputs; a set of pending beats a clear.
  always_ff @(posedge FPGA_CLK or negedge rst_butt) begin
    if (!rst_butt) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit     <= 3'd0;
      r_idx     <= 2'd0;
      r_shift   <= 8'h00;
      r_data_q  <= 4'h0;
      r_pending <= 1'b0;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_bit     <= w_bit_n;
      r_idx     <= w_idx_n;
      r_shift   <= w_shift_n;
      r_data_q  <= data;
      r_pending <= w_chg | (r_pending & ~w_take);
      r_txd     <= w_txd_n;
      r_busy    <= (w_state_n != S_IDLE);
      r_done    <= w_done_n;
    end
  end

  assign UART_TXD = r_txd;
  assign busy     = r_busy;
  assign msg_done = r_done;

endmodule
